// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID stage: FSM encoding, instruction field
// positions and the sequential PC step.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam int PC_INC = 4;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
interface if_id_stage_if #(
  parameter int W = 32
) ();
  // imem_req/imem_addr are held until the cycle imem_gnt is high; that cycle
  // is the transfer. imem_rvalid/imem_rdata come at least one cycle later and
  // are taken unconditionally (no back-pressure on the response).
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_id_stage_instr_field_decode.sv
// Purely combinational split of a 32-bit instruction word into its fields.
module instr_field_decode
  import if_id_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);
  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = instr[IMM_MSB:IMM_LSB];
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register: one outstanding imem request, a
// one-entry skid buffer for responses arriving under stall, redirect flush.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [W-1:0]  redirect_pc,
  output logic          id_valid,
  output logic [W-1:0]  id_pc,
  output logic [W-1:0]  id_pc_plus4,
  output logic [W-1:0]  id_instr,
  output logic [5:0]    id_opcode,
  output logic [4:0]    id_rs,
  output logic [4:0]    id_rt,
  output logic [4:0]    id_rd,
  output logic [4:0]    id_shamt,
  output logic [5:0]    id_funct,
  output logic [15:0]   id_imm16,
  output state_e        dbg_state
);
  localparam logic [W-1:0] PC_STEP = W'(PC_INC);

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] req_pc_q, req_pc_d;
  logic [W-1:0] skid_pc_q, skid_pc_d;
  logic [W-1:0] skid_instr_q, skid_instr_d;
  logic         id_valid_q, id_valid_d;
  logic [W-1:0] id_pc_q, id_pc_d;
  logic [W-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [W-1:0] id_instr_q, id_instr_d;
  logic         load_id;
  logic [W-1:0] load_pc, load_instr;
  logic [W-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {redirect_pc[W-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load_id      = 1'b0;
    load_pc      = req_pc_q;
    load_instr   = imem.imem_rdata;

    unique case (state_q)
      ST_FETCH: if (imem.imem_gnt) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
        state_d  = ST_WAIT;
      end
      ST_WAIT: if (imem.imem_rvalid) begin
        if (!stall) begin
          load_id = 1'b1;
          state_d = ST_FETCH;
        end else begin
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem.imem_rdata;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: if (!stall) begin
        load_id    = 1'b1;
        load_pc    = skid_pc_q;
        load_instr = skid_instr_q;
        state_d    = ST_FETCH;
      end
      ST_DRAIN: if (imem.imem_rvalid) state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase

    // Redirect wins over everything; a grant taken in the same cycle is still
    // outstanding, so its response has to be drained.
    if (redirect) begin
      load_id = 1'b0;
      pc_d    = redirect_pc_aligned;
      if (state_q == ST_FETCH)     state_d = imem.imem_gnt    ? ST_DRAIN : ST_FETCH;
      else if (state_q == ST_WAIT) state_d = imem.imem_rvalid ? ST_FETCH : ST_DRAIN;
      else if (state_q == ST_HOLD) state_d = ST_FETCH;
    end

    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    if (load_id) begin
      id_valid_d    = 1'b1;
      id_pc_d       = load_pc;
      id_pc_plus4_d = load_pc + PC_STEP;
      id_instr_d    = load_instr;
    end else if (!stall || redirect) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      skid_pc_q     <= '0;
      skid_instr_q  <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign id_instr       = id_instr_q;
  assign dbg_state      = state_q;

  instr_field_decode u_decode (
    .instr  (id_instr_q[31:0]),
    .opcode (id_opcode),
    .rs     (id_rs),
    .rt     (id_rt),
    .rd     (id_rd),
    .shamt  (id_shamt),
    .funct  (id_funct),
    .imm16  (id_imm16)
  );
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: decode vector table, directed multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  localparam int           W        = 32;
  localparam logic [W-1:0] RESET_PC = 32'h0000_0000;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         id_valid;
  logic [W-1:0] id_pc, id_pc_plus4, id_instr;
  logic [5:0]   id_opcode, id_funct;
  logic [4:0]   id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]  id_imm16;
  state_e       dbg_state;

  if_id_stage_if #(.W(W)) imem_bus ();

  if_id_stage #(.W(W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .id_imm16    (id_imm16),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];     // instructions expected to pass through ID, in order
  logic [W-1:0] exp_pc_q[$];  // their fetch addresses

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall                = 1'b0;
    redirect             = 1'b0;
    redirect_pc          = '0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_bus.imem_req && n < 16) begin
      tick();
      n++;
    end
    chk("req_timeout", 32'(imem_bus.imem_req), 1);
  endtask

  // Grant at the current cycle, respond the next one; ID is visible on return.
  task automatic fetch_one(input logic [31:0] instr, input logic [31:0] exp_addr);
    wait_req();
    chk("fetch_addr", imem_bus.imem_addr, exp_addr);
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    chk("wait_no_req", 32'(imem_bus.imem_req), 0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = instr;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
  endtask

  // ---------------- randomized phase with reference model ----------------
  task automatic random_phase(input int n_rand, input int n_drain);
    logic [W-1:0] exp_pc, mem_addr, e_pc, e_in;
    logic         out_valid, out_killed, mem_pending, prev_redirect, quiet;
    int           mem_delay, n_grants;
    exp_pc = RESET_PC; mem_addr = '0; out_valid = 0; out_killed = 0;
    mem_pending = 0; prev_redirect = 0; mem_delay = 0; n_grants = 0;
    exp_q.delete(); exp_pc_q.delete();
    do_reset();
    for (int cyc = 0; cyc < n_rand + n_drain; cyc++) begin
      tick();
      quiet = (cyc >= n_rand);
      if (prev_redirect) chk("rnd_redirect_flush", 32'(id_valid), 0);

      stall       = !quiet && ($urandom_range(0, 2) == 0);
      redirect    = !quiet && ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      imem_bus.imem_gnt    = !quiet && !mem_pending && imem_bus.imem_req &&
                             ($urandom_range(0, 1) == 1);
      imem_bus.imem_rvalid = mem_pending && (mem_delay == 0);
      imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_word(mem_addr) : $urandom;

      if (imem_bus.imem_gnt) chk("rnd_fetch_addr", imem_bus.imem_addr, exp_pc);

      // Whenever ID holds something it must be the oldest surviving response.
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_id", 32'(id_valid), 0);
        end else begin
          e_pc = exp_pc_q[0];
          e_in = exp_q[0];
          chk("rnd_id_pc", id_pc, e_pc);
          chk("rnd_id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
          chk("rnd_id_instr", id_instr, e_in);
          chk("rnd_opcode", 32'(id_opcode), 32'(e_in[31:26]));
          chk("rnd_rs", 32'(id_rs), 32'(e_in[25:21]));
          chk("rnd_rt", 32'(id_rt), 32'(e_in[20:16]));
          chk("rnd_rd", 32'(id_rd), 32'(e_in[15:11]));
          chk("rnd_shamt", 32'(id_shamt), 32'(e_in[10:6]));
          chk("rnd_funct", 32'(id_funct), 32'(e_in[5:0]));
          chk("rnd_imm16", 32'(id_imm16), 32'(e_in[15:0]));
          if (!stall && !redirect) begin
            void'(exp_q.pop_front());
            void'(exp_pc_q.pop_front());
          end
        end
      end

      if (imem_bus.imem_rvalid) begin
        if (out_valid && !out_killed && !redirect) begin
          exp_q.push_back(mem_word(exp_pc_q.size() >= 0 ? mem_addr : mem_addr));
          exp_pc_q.push_back(mem_addr);
        end
        out_valid   = 0;
        mem_pending = 0;
      end else if (mem_pending) begin
        mem_delay--;
      end
      if (imem_bus.imem_gnt) begin
        out_valid   = 1;
        out_killed  = 0;
        mem_pending = 1;
        mem_addr    = exp_pc;
        mem_delay   = $urandom_range(0, 2);
        n_grants++;
      end
      if (redirect) begin
        exp_q.delete();
        exp_pc_q.delete();
        out_killed = 1;
        exp_pc     = redirect_pc & ~32'h3;
      end else if (imem_bus.imem_gnt) begin
        exp_pc = exp_pc + 32'd4;
      end
      prev_redirect = redirect;
    end
    idle_inputs();
    tick();
    chk("rnd_queue_empty", 32'(exp_q.size()), 0);
    chk("rnd_final_id_valid", 32'(id_valid), 0);
    chk("rnd_progress", 32'(n_grants > 200), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{32'h2008_FFFF, 6'h08, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF};
    tbl[1] = '{32'h0000_0020, 6'h00, 5'd0, 5'd0,  5'd0,  5'd0,  6'h20, 16'h0020};
    tbl[2] = '{32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020};
    tbl[3] = '{32'h0004_1080, 6'h00, 5'd0, 5'd4,  5'd2,  5'd2,  6'h00, 16'h1080};
    tbl[4] = '{32'hFFFF_FFFF, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF};
    tbl[5] = '{32'h8C43_0004, 6'h23, 5'd2, 5'd3,  5'd0,  5'd0,  6'h04, 16'h0004};

    idle_inputs();
    #1;
    rst_n = 1'b0;
    tick();
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_pc_plus4", id_pc_plus4, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("rst_addr", imem_bus.imem_addr, RESET_PC);
    tick();
    rst_n = 1'b1;
    chk("rst_release_req", 32'(imem_bus.imem_req), 1);

    // Decode table, fetched back-to-back from RESET_PC.
    for (int i = 0; i < 6; i++) begin
      fetch_one(tbl[i].instr, RESET_PC + 32'(4 * i));
      chk("tbl_id_valid", 32'(id_valid), 1);
      chk("tbl_id_pc", id_pc, RESET_PC + 32'(4 * i));
      chk("tbl_id_pc_plus4", id_pc_plus4, RESET_PC + 32'(4 * i + 4));
      chk("tbl_id_instr", id_instr, tbl[i].instr);
      chk("tbl_opcode", 32'(id_opcode), 32'(tbl[i].opc));
      chk("tbl_rs", 32'(id_rs), 32'(tbl[i].rs));
      chk("tbl_rt", 32'(id_rt), 32'(tbl[i].rt));
      chk("tbl_rd", 32'(id_rd), 32'(tbl[i].rd));
      chk("tbl_shamt", 32'(id_shamt), 32'(tbl[i].sh));
      chk("tbl_funct", 32'(id_funct), 32'(tbl[i].fn));
      chk("tbl_imm16", 32'(id_imm16), 32'(tbl[i].imm));
    end
    tick();
    chk("accept_clears_valid", 32'(id_valid), 0);

    // Response under a 3-cycle stall parks in the skid buffer.
    fetch_one(32'h8C43_0004, 32'h18);
    stall = 1'b1;
    wait_req();
    chk("stall_fetch_addr", imem_bus.imem_addr, 32'h1C);
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h0000_0020;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hold_valid", 32'(id_valid), 1);
      chk("stall_hold_instr", id_instr, 32'h8C43_0004);
      chk("stall_hold_pc", id_pc, 32'h18);
      chk("stall_no_req", 32'(imem_bus.imem_req), 0);
      chk("stall_state_hold", 32'(dbg_state), 32'(ST_HOLD));
      tick();
    end
    stall = 1'b0;
    tick();
    chk("unstall_valid", 32'(id_valid), 1);
    chk("unstall_instr", id_instr, 32'h0000_0020);
    chk("unstall_funct", 32'(id_funct), 32'h20);
    chk("unstall_pc", id_pc, 32'h1C);
    chk("unstall_pc_plus4", id_pc_plus4, 32'h20);

    // Redirect in WAIT: the late response is drained, never loaded.
    wait_req();
    chk("drain_fetch_addr", imem_bus.imem_addr, 32'h20);
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("drain_no_req", 32'(imem_bus.imem_req), 0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("drain_id_valid", 32'(id_valid), 0);
    chk("drain_id_instr", id_instr, 32'h0000_0020);
    chk("drain_to_fetch", 32'(dbg_state), 32'(ST_FETCH));
    chk("drain_next_addr", imem_bus.imem_addr, 32'h100);
    fetch_one(32'h012A_4020, 32'h100);
    chk("redir_id_pc", id_pc, 32'h100);
    chk("redir_id_pc_plus4", id_pc_plus4, 32'h104);

    // Redirect together with rvalid: response dropped, misaligned target forced.
    wait_req();
    chk("same_cyc_fetch_addr", imem_bus.imem_addr, 32'h104);
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h1234_5678;
    redirect             = 1'b1;
    redirect_pc          = 32'h0000_0203;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    redirect             = 1'b0;
    chk("same_cyc_id_valid", 32'(id_valid), 0);
    chk("same_cyc_id_instr", id_instr, 32'h012A_4020);
    chk("same_cyc_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("same_cyc_addr", imem_bus.imem_addr, 32'h200);

    // Redirect with grant -> DRAIN; a second redirect in DRAIN only moves the PC.
    imem_bus.imem_gnt = 1'b1;
    redirect          = 1'b1;
    redirect_pc       = 32'h0000_0300;
    tick();
    imem_bus.imem_gnt = 1'b0;
    chk("gnt_redir_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("gnt_redir_no_req", 32'(imem_bus.imem_req), 0);
    redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    chk("drain_redir_state", 32'(dbg_state), 32'(ST_DRAIN));
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("drain_redir_exit", 32'(dbg_state), 32'(ST_FETCH));
    chk("drain_redir_addr", imem_bus.imem_addr, 32'h400);
    chk("drain_redir_valid", 32'(id_valid), 0);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_redir_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0004_1080, 32'hFFFF_FFFC);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc_plus4", id_pc_plus4, 32'h0);
    chk("wrap_shamt", 32'(id_shamt), 32'd2);
    chk("wrap_next_addr", imem_bus.imem_addr, 32'h0);

    // Reset in WAIT; the late response must be ignored.
    wait_req();
    imem_bus.imem_gnt = 1'b1;
    tick();
    imem_bus.imem_gnt = 1'b0;
    chk("mid_rst_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("mid_rst_valid", 32'(id_valid), 0);
    chk("mid_rst_instr", id_instr, 0);
    chk("mid_rst_req", 32'(imem_bus.imem_req), 1);
    tick();
    rst_n                = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hBAD0_0BAD;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    chk("late_rsp_valid", 32'(id_valid), 0);
    chk("late_rsp_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("late_rsp_addr", imem_bus.imem_addr, RESET_PC);
    fetch_one(32'h2008_FFFF, RESET_PC);
    chk("restart_id_pc", id_pc, RESET_PC);
    chk("restart_id_instr", id_instr, 32'h2008_FFFF);

    random_phase(3000, 24);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter W, 32, instruction and address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 imem_req  out  1  fetch request; held high until imem_gnt.
REQ-006 imem_addr  out  W  word-aligned fetch address (bits[1:0]=0); stable while imem_req high.
REQ-007 imem_gnt  in  1  request accepted in that cycle.
REQ-008 imem_rvalid / imem_rdata  in  1 / W  instruction response; arrives at least one cycle after the grant.
REQ-009 stall  in  1  decode stage cannot accept; the ID register holds.
REQ-010 redirect / redirect_pc  in  1 / W  branch, jump or flush; fetch restarts at redirect_pc.
REQ-011 id_valid, id_pc, id_pc_plus4, id_instr  out  1, W, W, W  registered ID-stage instruction.
REQ-012 id_opcode[5:0], id_rs[4:0], id_rt[4:0], id_rd[4:0], id_shamt[4:0], id_funct[5:0], id_imm16[15:0]  out  fields decoded combinationally from id_instr; id_imm16 drives the immediate sign-extension stage.

Function
REQ-013 FSM states: FETCH (imem_req=1), WAIT (one request outstanding), HOLD (response parked in skid buffer), DRAIN (discarding a stale response).
REQ-014 FETCH to WAIT on imem_gnt; the PC advances by 4 in the same edge.
REQ-015 WAIT with imem_rvalid and no stall: load the ID register (id_valid=1, id_pc=fetch address, id_pc_plus4=id_pc+4, id_instr=imem_rdata), then go to FETCH.
REQ-016 WAIT with imem_rvalid and stall: capture the response in a 1-entry skid buffer, then go to HOLD; no request is issued while in HOLD.
REQ-017 HOLD with stall low: move the skid entry into the ID register, then go to FETCH.
REQ-018 While stall is high, all ID outputs hold their values; id_valid clears on an accepted transfer only if no new instruction is loaded.
REQ-019 redirect has priority over stall and over every response: PC=redirect_pc, id_valid=0, skid buffer emptied.
REQ-020 redirect while in FETCH or HOLD goes to FETCH; redirect in WAIT (without rvalid that cycle) goes to DRAIN.
REQ-021 DRAIN discards the next imem_rvalid, then goes to FETCH; a further redirect in DRAIN only updates the PC.
REQ-022 redirect together with imem_rvalid in WAIT: the response is dropped and the next state is FETCH.
REQ-023 redirect together with imem_gnt in FETCH: the grant counts as outstanding, so the next state is DRAIN.
REQ-024 Latency: grant at cycle n and rvalid at n+1 give id_valid at n+2; peak throughput is one instruction per 2 cycles.
REQ-025 PC arithmetic is modulo 2^W; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is forced to 0.

Reset
REQ-026 Async assert: state=FETCH, PC=RESET_PC, id_valid=0, id_pc=0, id_pc_plus4=0, id_instr=0, skid buffer empty.
REQ-027 imem_req is high in the first cycle after rst_n deasserts; any response still in flight across reset is ignored (state is FETCH, not WAIT).

Structure
REQ-028 A shared package holds: the state encoding, field bit positions (OPC 31:26, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNCT 5:0, IMM 15:0), and the PC increment constant 4.
REQ-029 One sub-module, instr_field_decode, purely combinational, extracts the fields from id_instr.

Verification
REQ-030 Reset release, imem_gnt=1 immediately, rvalid next cycle with 32'h2008_FFFF -> imem_addr=0; then id_valid=1, id_pc=0, id_pc_plus4=4, id_opcode=6'h08, id_rt=8, id_imm16=16'hFFFF.
REQ-031 stall=1 for 3 cycles while rvalid arrives with 32'h0000_0020 -> ID outputs unchanged and no imem_req; after stall drops, id_instr=32'h0000_0020 and id_funct=6'h20.
REQ-032 redirect to 32'h0000_0100 while in WAIT, then rvalid with 32'hDEAD_BEEF -> DEAD_BEEF never reaches id_instr; the next imem_addr=32'h100.
REQ-033 redirect and rvalid in the same cycle -> response dropped, id_valid=0, next imem_addr=redirect_pc.
REQ-034 PC=32'hFFFF_FFFC fetched -> the next imem_addr=0.
REQ-035 rst_n asserted mid-WAIT, then a late rvalid -> no id_valid; the fetch restarts at RESET_PC.
